fp_min_stream: RTL and testbench

//  Streaming IEEE-754 minimum tracker, the min-side counterpart of the FPU max comparator.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_lt_cmp.sv | 34 +++
 rtl/fp_min_stream.sv | 120 ++++++++++++
 tb/tb_fp_min_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the min/max stream units.
// Default widths, state encoding, NaN detect and canonical quiet NaN.
package fp_pkg;
  localparam int NEXP = 8;
  localparam int NSIG = 23;
  localparam int W    = NEXP + NSIG + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  function automatic logic is_nan(input logic [W-1:0] x);
    return (x[W-2:NSIG] == {NEXP{1'b1}}) && (x[NSIG-1:0] != '0);
  endfunction
endpackage

// File: rtl/fp_lt_cmp.sv
// Combinational a < b under a total order on IEEE-754 encodings (-0 < +0).
// Shared between the min and max stream units.
module fp_lt_cmp
  import fp_pkg::*;
#(
  parameter int NEXP = fp_pkg::NEXP,
  parameter int NSIG = fp_pkg::NSIG
) (
  input  logic [NEXP+NSIG:0] a,
  input  logic [NEXP+NSIG:0] b,
  output logic               lt
);
  localparam int WD = NEXP + NSIG + 1;

  logic              sa;
  logic              sb;
  logic [WD-2:0]     ma;
  logic [WD-2:0]     mb;

  assign sa = a[WD-1];
  assign sb = b[WD-1];
  assign ma = a[WD-2:0];
  assign mb = b[WD-2:0];

  always_comb begin
    lt = 1'b0;
    if (sa != sb)
      lt = sa;
    else if (!sa)
      lt = (ma < mb);
    else
      lt = (ma > mb);  // negatives: larger magnitude is smaller
  end
endmodule

// File: rtl/fp_min_stream.sv
// Streaming running-minimum tracker over valid/ready frames; emits min, index and count.
// Optional NaN tracking is enabled by defining FP_MIN_NAN_CHECK_EN.
module fp_min_stream
  import fp_pkg::*;
#(
  parameter int NEXP = fp_pkg::NEXP,
  parameter int NSIG = fp_pkg::NSIG,
  parameter int IDXW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NEXP+NSIG:0]  in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NEXP+NSIG:0]  out_min,
  output logic [IDXW-1:0]     out_idx,
  output logic [IDXW-1:0]     out_count,
  output logic                out_ovf,
  output logic                out_nan
);
  localparam int WD = NEXP + NSIG + 1;

  state_t            state;
  logic [WD-1:0]     min_r;
  logic [IDXW-1:0]   idx_r;
  logic [IDXW-1:0]   cnt_r;
  logic [IDXW-1:0]   cnt_nxt;
  logic              ovf_r;
  logic              nan_r;
  logic              take;
  logic              lt;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign take      = in_valid && in_ready;
  assign cnt_nxt   = cnt_r + IDXW'(1);

  fp_lt_cmp #(.NEXP(NEXP), .NSIG(NSIG)) u_lt_cmp (
    .a  (in_data),
    .b  (min_r),
    .lt (lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      min_r <= '0;
      idx_r <= '0;
      cnt_r <= '0;
      ovf_r <= 1'b0;
      nan_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            min_r <= in_data;
            idx_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
            nan_r <= 1'b0;
`ifdef FP_MIN_NAN_CHECK_EN
            if (is_nan(in_data)) begin
              min_r <= QNAN;
              nan_r <= 1'b1;
            end
`endif
            state <= in_last ? HOLD : ACC;
          end
        end
        ACC: begin
          if (take) begin
            cnt_r <= cnt_nxt;
            if (cnt_r == '1)
              ovf_r <= 1'b1;
`ifdef FP_MIN_NAN_CHECK_EN
            // once a NaN is captured it pins the result for the rest of the frame
            if (!nan_r) begin
              if (is_nan(in_data)) begin
                min_r <= QNAN;
                idx_r <= cnt_nxt;
                nan_r <= 1'b1;
              end else if (lt) begin
                min_r <= in_data;
                idx_r <= cnt_nxt;
              end
            end
`else
            if (lt) begin
              min_r <= in_data;
              idx_r <= cnt_nxt;
            end
`endif
            if (in_last)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
            min_r <= '0;
            idx_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
            nan_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_min   = min_r;
  assign out_idx   = idx_r;
  assign out_count = cnt_r;
  assign out_ovf   = ovf_r;
  assign out_nan   = nan_r;
endmodule

// File: tb/tb_fp_min_stream.sv
// Directed self-checking bench for fp_min_stream (default widths, IDXW=8).
// Expectations for the NaN frame follow FP_MIN_NAN_CHECK_EN when defined.
module tb_fp_min_stream;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_min;
  logic [7:0]  out_idx;
  logic [7:0]  out_count;
  logic        out_ovf;
  logic        out_nan;

  int tests;
  int fails;

  fp_min_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one element; waits (bounded) for in_ready, then transfers on the next edge.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if ({out_min, out_idx, out_count, out_ovf, out_nan} !== 50'd0) begin
      fails++; $display("FAIL reset_outputs: min=%h idx=%h cnt=%h ovf=%0b nan=%0b want all 0",
                        out_min, out_idx, out_count, out_ovf, out_nan);
    end
  endtask

  task automatic test_basic();
    send(32'h40400000, 1'b0);
    send(32'hBFC00000, 1'b0);
    send(32'h40000000, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    tests++; if (out_min !== 32'hBFC00000) begin fails++; $display("FAIL basic_min: got %h want bfc00000", out_min); end
    tests++; if (out_idx !== 8'd1) begin fails++; $display("FAIL basic_idx: got %0d want 1", out_idx); end
    tests++; if (out_count !== 8'd2) begin fails++; $display("FAIL basic_count: got %0d want 2", out_count); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %0b want 0", out_ovf); end
    tests++; if (out_nan !== 1'b0) begin fails++; $display("FAIL basic_nan: got %0b want 0", out_nan); end
    release_result();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL basic_release: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_negative();
    send(32'hC0000000, 1'b0);
    send(32'hC1000000, 1'b1);
    tests++; if (out_min !== 32'hC1000000) begin fails++; $display("FAIL neg_min: got %h want c1000000", out_min); end
    tests++; if (out_idx !== 8'd1) begin fails++; $display("FAIL neg_idx: got %0d want 1", out_idx); end
    tests++; if (out_count !== 8'd1) begin fails++; $display("FAIL neg_count: got %0d want 1", out_count); end
    release_result();
  endtask

  task automatic test_zero_tie();
    send(32'h00000000, 1'b0);
    send(32'h80000000, 1'b0);
    send(32'h80000000, 1'b1);
    tests++; if (out_min !== 32'h80000000) begin fails++; $display("FAIL tie_min: got %h want 80000000", out_min); end
    tests++; if (out_idx !== 8'd1) begin fails++; $display("FAIL tie_idx: got %0d want 1", out_idx); end
    tests++; if (out_count !== 8'd2) begin fails++; $display("FAIL tie_count: got %0d want 2", out_count); end
    release_result();
  endtask

  task automatic test_backpressure();
    send(32'h41200000, 1'b0);
    send(32'h3F000000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hFF800000;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold_c%0d: ready=%0b valid=%0b want 0/1", c, in_ready, out_valid);
      end
      tests++; if (out_min !== 32'h3F000000 || out_idx !== 8'd1 || out_count !== 8'd1) begin
        fails++; $display("FAIL bp_stable_c%0d: min=%h idx=%0d cnt=%0d want 3f000000/1/1", c, out_min, out_idx, out_count);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_idle_ready: got %0b want 1", in_ready); end
    send(32'h12345678, 1'b1);
    tests++; if (out_valid !== 1'b1 || out_min !== 32'h12345678 || out_idx !== 8'd0 || out_count !== 8'd0) begin
      fails++; $display("FAIL bp_next_single: valid=%0b min=%h idx=%0d cnt=%0d want 1/12345678/0/0",
                        out_valid, out_min, out_idx, out_count);
    end
    release_result();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 257; i++)
      send((i == 256) ? 32'hBF800000 : 32'h3F800000, (i == 256));
    tests++; if (out_ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %0b want 1", out_ovf); end
    tests++; if (out_count !== 8'h00) begin fails++; $display("FAIL ovf_count: got %h want 00", out_count); end
    tests++; if (out_idx !== 8'h00) begin fails++; $display("FAIL ovf_idx: got %h want 00", out_idx); end
    tests++; if (out_min !== 32'hBF800000) begin fails++; $display("FAIL ovf_min: got %h want bf800000", out_min); end
    release_result();
  endtask

  task automatic test_nan();
    logic [31:0] exp_min;
    logic [7:0]  exp_idx;
    logic        exp_nan;
`ifdef FP_MIN_NAN_CHECK_EN
    exp_min = 32'h7FC00000; exp_idx = 8'd1; exp_nan = 1'b1;
`else
    exp_min = 32'hC0A00000; exp_idx = 8'd2; exp_nan = 1'b0;
`endif
    send(32'h3F800000, 1'b0);
    send(32'h7F800001, 1'b0);
    send(32'hC0A00000, 1'b1);
    tests++; if (out_min !== exp_min) begin fails++; $display("FAIL nan_min: got %h want %h", out_min, exp_min); end
    tests++; if (out_idx !== exp_idx) begin fails++; $display("FAIL nan_idx: got %0d want %0d", out_idx, exp_idx); end
    tests++; if (out_nan !== exp_nan) begin fails++; $display("FAIL nan_flag: got %0b want %0b", out_nan, exp_nan); end
    tests++; if (out_count !== 8'd2) begin fails++; $display("FAIL nan_count: got %0d want 2", out_count); end
    release_result();
  endtask

  task automatic test_reset_midframe();
    send(32'hC2000000, 1'b0);
    send(32'hC3000000, 1'b0);
    rst_n = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_ctrl: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
    tests++; if ({out_min, out_idx, out_count, out_ovf, out_nan} !== 50'd0) begin
      fails++; $display("FAIL rst_mid_outputs: min=%h idx=%h cnt=%h want all 0", out_min, out_idx, out_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_no_valid_c%0d: got %0b want 0", c, out_valid); end
    end
    send(32'h40A00000, 1'b1);
    tests++; if (out_min !== 32'h40A00000 || out_idx !== 8'd0 || out_count !== 8'd0) begin
      fails++; $display("FAIL rst_mid_fresh: min=%h idx=%0d cnt=%0d want 40a00000/0/0", out_min, out_idx, out_count);
    end
    release_result();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_negative();
    test_zero_tie();
    test_backpressure();
    test_overflow();
    test_nan();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
